// File: rtl/sdram_cmd_responder.sv
// Stands in for the SDRAM device on the controller's command bus: decodes commands, tracks
// init/mode/open banks, flags tRP/tMRD/tRFC/tRCD and protocol errors, serves bursts from 64x16.
//
// init state   | meaning
// ST_PRE_A     | expecting PRE all-banks (A10=1)
// ST_LMR_EXT   | expecting LMR to extended mode register (BA=01)
// ST_LMR_MODE  | expecting LMR to mode register (BA=00)
// ST_PRE_B     | expecting second PRE all-banks
// ST_REF_A     | expecting first AREF
// ST_REF_B     | expecting second AREF
// ST_LMR_FINAL | expecting final LMR (BA=00); initDone rises next cycle
`timescale 1ns/1ps
module sdram_cmd_responder #(
   parameter int tRP  = 3,
   parameter int tMRD = 2,
   parameter int tRFC = 11,
   parameter int tRCD = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sd_CKE,
   input  logic        sd_CS,
   input  logic        sd_RAS,
   input  logic        sd_CAS,
   input  logic        sd_WE,
   input  logic [12:0] sd_A,
   input  logic [1:0]  sd_BA,
   input  logic [15:0] wrData,
   output logic [15:0] rdData,
   output logic        rdValid,
   output logic [12:0] modeReg,
   output logic [12:0] extModeReg,
   output logic [3:0]  bankOpen,
   output logic        initDone,
   output logic        violation,
   output logic [2:0]  violationCode
);
   localparam logic [2:0] CMD_LMR  = 3'b000;
   localparam logic [2:0] CMD_AREF = 3'b001;
   localparam logic [2:0] CMD_PRE  = 3'b010;
   localparam logic [2:0] CMD_ACT  = 3'b011;
   localparam logic [2:0] CMD_WR   = 3'b100;
   localparam logic [2:0] CMD_RD   = 3'b101;
   localparam logic [2:0] CMD_NOP  = 3'b111;
   // Down-counters are loaded with tX-1 so a nonzero count at a later edge means k < tX.
   localparam logic [7:0] TRP_LD  = 8'(tRP - 1);
   localparam logic [7:0] TMRD_LD = 8'(tMRD - 1);
   localparam logic [7:0] TRFC_LD = 8'(tRFC - 1);
   localparam logic [7:0] TRCD_LD = 8'(tRCD - 1);

   typedef enum logic [2:0] {
      ST_PRE_A, ST_LMR_EXT, ST_LMR_MODE, ST_PRE_B, ST_REF_A, ST_REF_B, ST_LMR_FINAL
   } init_state_t;

   init_state_t      state_q, state_d;
   logic             init_done_q, init_done_d;
   logic [12:0]      mode_q, mode_d, ext_q, ext_d;
   logic [3:0]       bank_open_q, bank_open_d;
   logic [3:0][12:0] row_q, row_d;
   logic [7:0]       trp_q, trp_d, tmrd_q, tmrd_d, trfc_q, trfc_d;
   logic [3:0][7:0]  trcd_q, trcd_d;
   logic             viol_q, viol_d;
   logic [2:0]       vcode_q, vcode_d;
   logic             burst_wr_q, burst_wr_d;
   logic [1:0]       burst_bank_q, burst_bank_d;
   logic [3:0]       burst_col_q, burst_col_d, burst_mask_q, burst_mask_d;
   logic [2:0]       burst_left_q, burst_left_d;
   logic [2:0]       pipe_vld_q, pipe_vld_d;
   logic [2:0][15:0] pipe_dat_q, pipe_dat_d;
   logic             rd_valid_q, rd_valid_d;
   logic [15:0]      rd_data_q, rd_data_d;
   logic [15:0]      mem_q [64];

   logic [2:0] cmd, err_code;
   logic       is_lmr, is_aref, is_pre, is_act, is_wr, is_rd, is_rw, is_nop;
   logic       step_match, rw_ok, act_ok, cl3, rd_beat, mem_we;
   logic [7:0] err;
   logic [3:0] bl_mask;
   logic [5:0] rd_addr, mem_waddr;
   logic [15:0] mem_wdata;
   logic       unused_row;

   function automatic logic [3:0] wrap_inc(input logic [3:0] col, input logic [3:0] mask);
      return (col & ~mask) | ((col + 4'd1) & mask);
   endfunction

   always_comb begin
      cmd = CMD_NOP;
      if (sd_CKE && !sd_CS) cmd = {sd_RAS, sd_CAS, sd_WE};
      is_lmr  = cmd == CMD_LMR;
      is_aref = cmd == CMD_AREF;
      is_pre  = cmd == CMD_PRE;
      is_act  = cmd == CMD_ACT;
      is_wr   = cmd == CMD_WR;
      is_rd   = cmd == CMD_RD;
      is_rw   = is_wr || is_rd;
      is_nop  = cmd == CMD_NOP || cmd == 3'b110;
      step_match = 1'b0;
      case (state_q)
         ST_PRE_A, ST_PRE_B:        step_match = is_pre && sd_A[10];
         ST_LMR_EXT:                step_match = is_lmr && sd_BA == 2'b01;
         ST_LMR_MODE, ST_LMR_FINAL: step_match = is_lmr && sd_BA == 2'b00;
         ST_REF_A, ST_REF_B:        step_match = is_aref;
         default:                   step_match = 1'b0;
      endcase
      err[0] = !init_done_q && !is_nop && (is_rw || !step_match);
      err[1] = !is_nop && trp_q != 8'd0;
      err[2] = !is_nop && tmrd_q != 8'd0;
      err[3] = !is_nop && trfc_q != 8'd0;
      err[4] = is_rw && trcd_q[sd_BA] != 8'd0;
      err[5] = is_rw && !bank_open_q[sd_BA];
      err[6] = is_act && bank_open_q[sd_BA];
      err[7] = (is_lmr || is_aref) && |bank_open_q;
      err_code = 3'd0;
      for (int i = 7; i >= 0; i--) if (err[i]) err_code = 3'(i);
      rw_ok  = is_rw && init_done_q && bank_open_q[sd_BA];
      act_ok = is_act && !bank_open_q[sd_BA];
      case (mode_q[2:0])
         3'b001:  bl_mask = 4'd1;
         3'b010:  bl_mask = 4'd3;
         3'b011:  bl_mask = 4'd7;
         default: bl_mask = 4'd0;
      endcase
      cl3 = mode_q[6:4] == 3'b011;
   end

   always_comb begin
      state_d     = state_q;
      init_done_d = init_done_q;
      mode_d      = mode_q;
      ext_d       = ext_q;
      bank_open_d = bank_open_q;
      row_d       = row_q;
      trp_d  = (trp_q  != 8'd0) ? trp_q  - 8'd1 : 8'd0;
      tmrd_d = (tmrd_q != 8'd0) ? tmrd_q - 8'd1 : 8'd0;
      trfc_d = (trfc_q != 8'd0) ? trfc_q - 8'd1 : 8'd0;
      for (int b = 0; b < 4; b++) trcd_d[b] = (trcd_q[b] != 8'd0) ? trcd_q[b] - 8'd1 : 8'd0;
      viol_d  = |err;
      vcode_d = (|err) ? err_code : vcode_q;

      if (!init_done_q && !is_nop) begin
         if (step_match) begin
            case (state_q)
               ST_PRE_A:     state_d = ST_LMR_EXT;
               ST_LMR_EXT:   state_d = ST_LMR_MODE;
               ST_LMR_MODE:  state_d = ST_PRE_B;
               ST_PRE_B:     state_d = ST_REF_A;
               ST_REF_A:     state_d = ST_REF_B;
               ST_REF_B:     state_d = ST_LMR_FINAL;
               ST_LMR_FINAL: init_done_d = 1'b1;
               default:      state_d = ST_PRE_A;
            endcase
         end else begin
            state_d = ST_PRE_A;
         end
      end

      if (is_pre) begin
         trp_d = TRP_LD;
         if (sd_A[10]) bank_open_d = 4'b0000;
         else          bank_open_d[sd_BA] = 1'b0;
      end
      if (is_lmr) begin
         tmrd_d = TMRD_LD;
         if (sd_BA == 2'b00)      mode_d = sd_A;
         else if (sd_BA == 2'b01) ext_d  = sd_A;
      end
      if (is_aref) trfc_d = TRFC_LD;
      if (act_ok) begin
         bank_open_d[sd_BA] = 1'b1;
         row_d[sd_BA]       = sd_A;
         trcd_d[sd_BA]      = TRCD_LD;
      end

      // An accepted READ/WRITE restarts the burst engine, cutting off any burst in flight.
      burst_wr_d   = burst_wr_q;
      burst_bank_d = burst_bank_q;
      burst_col_d  = burst_col_q;
      burst_mask_d = burst_mask_q;
      burst_left_d = burst_left_q;
      mem_we    = 1'b0;
      mem_waddr = 6'd0;
      mem_wdata = wrData;
      rd_beat   = 1'b0;
      rd_addr   = 6'd0;
      if (rw_ok) begin
         burst_wr_d   = is_wr;
         burst_bank_d = sd_BA;
         burst_mask_d = bl_mask;
         burst_col_d  = wrap_inc(sd_A[3:0], bl_mask);
         burst_left_d = bl_mask[2:0];
         mem_we    = is_wr;
         rd_beat   = is_rd;
         mem_waddr = {sd_BA, sd_A[3:0]};
         rd_addr   = {sd_BA, sd_A[3:0]};
      end else if (burst_left_q != 3'd0) begin
         burst_left_d = burst_left_q - 3'd1;
         burst_col_d  = wrap_inc(burst_col_q, burst_mask_q);
         mem_we    = burst_wr_q;
         rd_beat   = !burst_wr_q;
         mem_waddr = {burst_bank_q, burst_col_q};
         rd_addr   = {burst_bank_q, burst_col_q};
      end

      pipe_vld_d = {1'b0, pipe_vld_q[2:1]};
      pipe_dat_d = {16'h0000, pipe_dat_q[2:1]};
      if (rd_beat) begin
         if (cl3) begin
            pipe_vld_d[2] = 1'b1;
            pipe_dat_d[2] = mem_q[rd_addr];
         end else begin
            pipe_vld_d[1] = 1'b1;
            pipe_dat_d[1] = mem_q[rd_addr];
         end
      end
      rd_valid_d = pipe_vld_q[0];
      rd_data_d  = pipe_vld_q[0] ? pipe_dat_q[0] : 16'h0000;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_PRE_A;
         init_done_q  <= 1'b0;
         mode_q       <= '0;
         ext_q        <= '0;
         bank_open_q  <= '0;
         row_q        <= '0;
         trp_q        <= '0;
         tmrd_q       <= '0;
         trfc_q       <= '0;
         trcd_q       <= '0;
         viol_q       <= 1'b0;
         vcode_q      <= '0;
         burst_wr_q   <= 1'b0;
         burst_bank_q <= '0;
         burst_col_q  <= '0;
         burst_mask_q <= '0;
         burst_left_q <= '0;
         pipe_vld_q   <= '0;
         pipe_dat_q   <= '0;
         rd_valid_q   <= 1'b0;
         rd_data_q    <= '0;
      end else begin
         state_q      <= state_d;
         init_done_q  <= init_done_d;
         mode_q       <= mode_d;
         ext_q        <= ext_d;
         bank_open_q  <= bank_open_d;
         row_q        <= row_d;
         trp_q        <= trp_d;
         tmrd_q       <= tmrd_d;
         trfc_q       <= trfc_d;
         trcd_q       <= trcd_d;
         viol_q       <= viol_d;
         vcode_q      <= vcode_d;
         burst_wr_q   <= burst_wr_d;
         burst_bank_q <= burst_bank_d;
         burst_col_q  <= burst_col_d;
         burst_mask_q <= burst_mask_d;
         burst_left_q <= burst_left_d;
         pipe_vld_q   <= pipe_vld_d;
         pipe_dat_q   <= pipe_dat_d;
         rd_valid_q   <= rd_valid_d;
         rd_data_q    <= rd_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem_q[mem_waddr] <= mem_wdata;
   end

   // Open rows are kept for visibility only; the array is addressed by bank and column.
   assign unused_row    = ^row_q;
   assign rdData        = rd_data_q;
   assign rdValid       = rd_valid_q;
   assign modeReg       = mode_q;
   assign extModeReg    = ext_q;
   assign bankOpen      = bank_open_q;
   assign initDone      = init_done_q;
   assign violation     = viol_q;
   assign violationCode = vcode_q;
endmodule

// File: tb/tb_sdram_cmd_responder.sv
// Bench for sdram_cmd_responder: directed bring-up, timing and bank-error cases, then random
// command traffic, all compared each cycle against a timestamp-based reference model.
`timescale 1ns/1ps
module tb_sdram_cmd_responder;
   localparam int TRP = 3, TMRD = 2, TRFC = 11, TRCD = 2;
   localparam int LMR = 0, AREF = 1, PRE = 2, ACT = 3, WR = 4, RD = 5, NOP = 7;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        sd_CKE = 1'b0, sd_CS = 1'b1, sd_RAS = 1'b1, sd_CAS = 1'b1, sd_WE = 1'b1;
   logic [12:0] sd_A = '0;
   logic [1:0]  sd_BA = '0;
   logic [15:0] wrData = '0;
   logic [15:0] rdData;
   logic        rdValid, initDone, violation;
   logic [12:0] modeReg, extModeReg;
   logic [3:0]  bankOpen;
   logic [2:0]  violationCode;

   sdram_cmd_responder #(.tRP(TRP), .tMRD(TMRD), .tRFC(TRFC), .tRCD(TRCD)) dut (
      .clk(clk), .rst_n(rst_n), .sd_CKE(sd_CKE), .sd_CS(sd_CS), .sd_RAS(sd_RAS),
      .sd_CAS(sd_CAS), .sd_WE(sd_WE), .sd_A(sd_A), .sd_BA(sd_BA), .wrData(wrData),
      .rdData(rdData), .rdValid(rdValid), .modeReg(modeReg), .extModeReg(extModeReg),
      .bankOpen(bankOpen), .initDone(initDone), .violation(violation),
      .violationCode(violationCode)
   );

   always #5 clk = ~clk;

   int n_asrt = 0, n_fail = 0;

   // reference model state: times are edge indices of the last command of each kind
   int          e, t_pre, t_lmr, t_ref, step_i, exp_code;
   int          t_act [4];
   bit [3:0]    open_v;
   bit          m_done, exp_viol;
   logic [12:0] m_mode, m_ext;
   logic [15:0] mem [64];
   bit          known [64];
   bit          b_act, b_wr;
   int          b_start, b_bl, b_ba, b_a;
   bit          sv [int];
   logic [15:0] sd [int];
   bit          sk [int];
   int init_cmd [7] = '{PRE, LMR, LMR, PRE, AREF, AREF, LMR};
   int init_ba  [7] = '{-1, 1, 0, -1, -1, -1, 0};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      t_pre = -100; t_lmr = -100; t_ref = -100;
      for (int b = 0; b < 4; b++) t_act[b] = -100;
      for (int i = 0; i < 64; i++) known[i] = 1'b0;
      open_v = '0; m_done = 0; step_i = 0; exp_viol = 0; exp_code = 0;
      m_mode = '0; m_ext = '0; b_act = 0;
      sv.delete(); sd.delete(); sk.delete();
   endtask

   function automatic int bl_of(input logic [12:0] m);
      case (m[2:0])
         3'd1: return 2;
         3'd2: return 4;
         3'd3: return 8;
         default: return 1;
      endcase
   endfunction

   function automatic int cl_of(input logic [12:0] m);
      return (m[6:4] == 3'd3) ? 3 : 2;
   endfunction

   task automatic model_edge(input int c_raw, input bit en, input int ba, input logic [12:0] a,
                             input logic [15:0] wd);
      int c, col, addr, tt;
      bit nop, rw, match;
      bit v [8];
      c = en ? c_raw : NOP;
      if (c == 6) c = NOP;
      nop = (c == NOP);
      rw  = (c == WR || c == RD);
      match = 0;
      if (!m_done && c == init_cmd[step_i]) begin
         if (c == PRE)      match = a[10];
         else if (c == LMR) match = (ba == init_ba[step_i]);
         else               match = 1;
      end
      v[0] = !m_done && !nop && (rw || !match);
      v[1] = !nop && (e - t_pre < TRP);
      v[2] = !nop && (e - t_lmr < TMRD);
      v[3] = !nop && (e - t_ref < TRFC);
      v[4] = rw && (e - t_act[ba] < TRCD);
      v[5] = rw && !open_v[ba];
      v[6] = (c == ACT) && open_v[ba];
      v[7] = (c == LMR || c == AREF) && (open_v != 0);
      exp_viol = 0;
      for (int i = 0; i < 8; i++) if (v[i] && !exp_viol) begin exp_viol = 1; exp_code = i; end

      if (rw && m_done && open_v[ba]) begin
         b_act = 1; b_wr = (c == WR); b_start = e; b_bl = bl_of(m_mode); b_ba = ba;
         b_a = int'(a[3:0]);
      end
      if (b_act && (e - b_start) < b_bl) begin
         col  = (b_a - b_a % b_bl) + (b_a + (e - b_start)) % b_bl;
         addr = b_ba * 16 + col;
         if (b_wr) begin
            mem[addr] = wd; known[addr] = 1;
         end else begin
            tt = e + cl_of(m_mode);
            sv[tt] = 1; sd[tt] = mem[addr]; sk[tt] = known[addr];
         end
      end else begin
         b_act = 0;
      end

      if (c == PRE) begin
         t_pre = e;
         if (a[10]) open_v = '0; else open_v[ba] = 0;
      end
      if (c == LMR) begin
         t_lmr = e;
         if (ba == 0) m_mode = a; else if (ba == 1) m_ext = a;
      end
      if (c == AREF) t_ref = e;
      if (c == ACT && !v[6]) begin open_v[ba] = 1; t_act[ba] = e; end
      if (!m_done && !nop) begin
         if (match) begin
            if (step_i == 6) m_done = 1; else step_i++;
         end else step_i = 0;
      end
      e++;
   endtask

   task automatic check_all();
      int le = e - 1;
      check("violation", violation, exp_viol);
      check("violationCode", violationCode, exp_code);
      check("bankOpen", bankOpen, open_v);
      check("initDone", initDone, m_done);
      check("modeReg", modeReg, m_mode);
      check("extModeReg", extModeReg, m_ext);
      check("rdValid", rdValid, sv.exists(le));
      if (sv.exists(le) && sk[le]) check("rdData", rdData, sd[le]);
   endtask

   task automatic drive(input int c, input int ba, input int a, input int wd, input bit cke,
                        input bit csn);
      sd_CKE = cke; sd_CS = csn;
      {sd_RAS, sd_CAS, sd_WE} = 3'(c);
      sd_BA = 2'(ba); sd_A = 13'(a); wrData = 16'(wd);
      @(posedge clk);
      model_edge(c, cke && !csn, ba, 13'(a), 16'(wd));
      @(negedge clk);
      check_all();
   endtask

   task automatic step(input int c, input int ba, input int a, input int wd);
      drive(c, ba, a, wd, 1'b1, 1'b0);
   endtask

   task automatic nops(input int n);
      for (int i = 0; i < n; i++) step(NOP, 0, 0, 0);
   endtask

   task automatic run_init();
      step(PRE, 0, 13'h400, 0); nops(2);
      step(LMR, 1, 0, 0);       nops(1);
      step(LMR, 0, 13'h021, 0); nops(1);
      step(PRE, 0, 13'h400, 0); nops(2);
      step(AREF, 0, 0, 0);      nops(10);
      step(AREF, 0, 0, 0);      nops(10);
      step(LMR, 0, 13'h021, 0);
   endtask

   initial begin
      int r, c, ba, a, wd;
      e = 0;
      model_reset();
      repeat (2) @(negedge clk);
      check("reset_rdValid", rdValid, 0);
      check("reset_rdData", rdData, 0);
      check("reset_violation", violation, 0);
      check("reset_code", violationCode, 0);
      check("reset_bankOpen", bankOpen, 0);
      check("reset_initDone", initDone, 0);
      check("reset_modeReg", modeReg, 0);
      check("reset_extModeReg", extModeReg, 0);
      rst_n = 1'b1;

      run_init();
      check("init_done", initDone, 1);
      check("init_mode", modeReg, 13'h021);
      check("init_no_violation", violation, 0);

      nops(1);
      step(ACT, 1, 13'h055, 0); nops(1);
      step(WR, 1, 4, 16'hAAAA);
      step(NOP, 0, 0, 16'h5555);
      step(RD, 1, 4, 0);
      nops(1); check("rd_cl_gap", rdValid, 0);
      nops(1); check("rd_beat0_valid", rdValid, 1); check("rd_beat0_data", rdData, 16'hAAAA);
      nops(1); check("rd_beat1_valid", rdValid, 1); check("rd_beat1_data", rdData, 16'h5555);
      nops(1); check("rd_burst_end", rdValid, 0);

      step(PRE, 0, 13'h400, 0); nops(2);
      step(AREF, 0, 0, 0); nops(9);
      step(ACT, 0, 0, 0);
      check("trfc_k10_viol", violation, 1); check("trfc_k10_code", violationCode, 3);
      step(PRE, 0, 13'h400, 0); nops(2);
      step(AREF, 0, 0, 0); nops(10);
      step(ACT, 0, 0, 0);
      check("trfc_k11_clean", violation, 0);
      step(RD, 0, 0, 0);
      check("trcd_viol", violation, 1); check("trcd_code", violationCode, 4);
      nops(4);
      step(RD, 2, 0, 0);
      check("closed_viol", violation, 1); check("closed_code", violationCode, 5);
      nops(2); check("closed_no_data", rdValid, 0);
      nops(1);
      step(ACT, 0, 13'h123, 0);
      check("act_open_code", violationCode, 6);
      nops(1);
      step(AREF, 0, 0, 0);
      check("aref_open_code", violationCode, 7);

      nops(11);
      step(WR, 0, 8, 16'h1234);
      step(NOP, 0, 0, 16'h5678);
      step(RD, 0, 8, 0);
      nops(2);
      check("pre_reset_valid", rdValid, 1); check("pre_reset_data", rdData, 16'h1234);
      rst_n = 1'b0;
      #1;
      check("rst_rdValid", rdValid, 0);
      check("rst_rdData", rdData, 0);
      check("rst_bankOpen", bankOpen, 0);
      check("rst_modeReg", modeReg, 0);
      check("rst_extModeReg", extModeReg, 0);
      check("rst_code", violationCode, 0);
      check("rst_initDone", initDone, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      #1 check("post_rst_initDone", initDone, 0);

      step(PRE, 0, 13'h400, 0); nops(2);
      step(ACT, 0, 0, 0);
      check("order_act_viol", violation, 1); check("order_act_code", violationCode, 0);
      step(LMR, 1, 0, 0);
      check("order_restart_viol", violation, 1); check("order_restart_code", violationCode, 0);
      nops(2);
      run_init();
      check("reinit_done", initDone, 1);
      check("reinit_clean", violation, 0);

      for (int i = 0; i < 300; i++) begin
         r  = $urandom_range(99);
         ba = $urandom_range(3);
         a  = $urandom_range(8191);
         wd = $urandom_range(65535);
         if (r < 35)      c = NOP;
         else if (r < 55) c = ACT;
         else if (r < 70) c = WR;
         else if (r < 85) c = RD;
         else if (r < 95) c = PRE;
         else if (r < 97) c = AREF;
         else if (r < 98) begin
            c = LMR;
            a = $urandom_range(3) + 16 * $urandom_range(2, 3);
         end else c = 6;
         drive(c, ba, a, wd, $urandom_range(19) != 0, $urandom_range(19) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule

// File: doc/sdram_cmd_responder.md
# sdram_cmd_responder

Cycle-level responder for the SDRAM command bus our controller drives. It decodes CS/RAS/CAS/WE/A/BA, tracks the mode registers, the init sequence and per-bank open rows, and enforces tRP/tMRD/tRFC/tRCD. It serves READ/WRITE bursts from a small internal array, so the controller can be brought up and regressed on-chip or in simulation without a physical part. It sits on the memory side of the command bus, in place of the DDR device.

## Interface
Parameters:
- tRP, 3, precharge-to-next-command cycles
- tMRD, 2, load-mode-to-next-command cycles
- tRFC, 11, auto-refresh-to-next-command cycles
- tRCD, 2, activate-to-READ/WRITE cycles (same bank)

Ports:
- clk  in  1  single clock; all inputs sampled on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- sd_CKE  in  1  clock enable; 0 forces every command to NOP
- sd_CS  in  1  chip select, active low; 1 forces NOP
- sd_RAS, sd_CAS, sd_WE  in  1 each  command = {RAS,CAS,WE}
- sd_A  in  13  row, column or mode value
- sd_BA  in  2  bank address
- wrData  in  16  write data, one word per clk during a write burst
- rdData  out  16  read data
- rdValid  out  1  rdData is valid this cycle
- modeReg  out  13  last LMR value with BA=00
- extModeReg  out  13  last LMR value with BA=01
- bankOpen  out  4  per-bank row-open flags
- initDone  out  1  init sequence completed
- violation  out  1  one-cycle pulse on a protocol or timing error
- violationCode  out  3  error cause, held until the next violation

## Operation
- Command encoding: 000 LMR, 001 AREF, 010 PRE, 011 ACT, 100 WRITE, 101 READ, 111 NOP. 110 is treated as NOP.
- PRE with A[10]=1 closes all banks. With A[10]=0 it closes bank sd_BA only.
- ACT opens bank sd_BA and stores row A.
- The storage array is 64x16, indexed by {BA, A[3:0]}. Row is tracked but not used for addressing.
- Burst length comes from modeReg[2:0]: 000→1, 001→2, 010→4, 011→8. Any other value→1.
- Burst addresses wrap within a BL-aligned block of A[3:0].
- CAS latency comes from modeReg[6:4]: 010→2, 011→3. Any other value→2.
- Init sequence: PRE(A10=1), LMR(BA=01), LMR(BA=00), PRE(A10=1), AREF, AREF, LMR(BA=00).
  - A 3-bit step counter advances on each matching command.
  - NOPs are ignored during init.
  - Any other command before initDone raises code 0, and the counter returns to step 0.
  - initDone is set one cycle after the final LMR and is cleared only by reset.
- Violation codes (the offending command is still executed, except for codes 5 and 6):
  - 1: a command arrives while the tRP window is open.
  - 2: a command arrives while the tMRD window is open.
  - 3: a command arrives while the tRFC window is open.
  - 4: READ/WRITE to a bank whose tRCD window is open.
  - 5: READ/WRITE to a closed bank. The access is dropped.
  - 6: ACT to an already-open bank. The row is unchanged.
  - 7: LMR or AREF while any bank is open.
- READ or WRITE before initDone raises code 0 and is dropped.
- If several violations apply at once, the lowest nonzero code wins; code 0 outranks all others.

## Timing
- Reset values:
  - rdData=0, rdValid=0, violation=0, violationCode=0.
  - modeReg=0, extModeReg=0, bankOpen=0, initDone=0.
  - All timers are 0. The array contents are undefined.
- A command sampled at edge n opens its window, of length tX. Any non-NOP command at edge n+k with k<tX violates; k=tX is legal.
- tRCD is tracked per bank. The other timers are global.
- WRITE at edge n: wrData is stored at edges n through n+BL-1.
- READ at edge n: rdValid is high and rdData valid after edges n+CL through n+CL+BL-1.
- A new READ/WRITE during an active burst terminates the old burst at that edge. Read data already in the CL pipeline is still delivered, then the new burst follows.
- violation pulses on the cycle after the offending edge.
- Asserting rst_n low mid-burst clears all state immediately. rdValid drops asynchronously.

## Test plan
- Legal init: PRE(A10=1), NOP×2, LMR BA=01, NOP, LMR BA=00 A=0x021, NOP, PRE, NOP×2, AREF, NOP×10, AREF, NOP×10, LMR A=0x021 → initDone=1; modeReg=0x021; no violation.
- Write/read, BL=2, CL=2: ACT BA=1, NOP, WRITE A=0x4 with wrData 0xAAAA, 0x5555, then READ A=0x4 → rdValid at edges n+2 and n+3, data 0xAAAA, 0x5555.
- Timing edges: AREF then ACT at k=10 → code 3. Repeat at k=11 → no violation. ACT then READ at k=1 → code 4.
- Bank errors: READ to closed bank 2 → code 5 and no rdValid. ACT twice to bank 0 → code 6. AREF with bank 0 open → code 7.
- Init order: ACT issued before initDone → code 0, and the step counter restarts.
- Reset mid-read: rst_n low during rdValid → all outputs 0 in the same cycle; after release initDone=0.
